// File: rtl/stack_ctrl_sequencer.sv
// stack_ctrl_sequencer
//   Multi-cycle control sequencer for the 16-bit stack CPU. It takes
//   instruction words from fetch over a valid/ready handshake and latches
//   each word into an instruction register (IR). It runs ALU ops in one cycle
//   and stack ops that write back in two cycles. It owns the stack pointer,
//   turns push-when-full and pop-when-empty into a sticky fault, and drives
//   the datapath control strobes from registered state.
//
//   Instruction bits are numbered big-endian. Bit 0 is the MSB of i_instr.
//   Only bits 0..17 are meaningful. JW must be <= 6.
//
// Ports
//   i_clk, i_rst      clock; asynchronous active-high reset
//   i_instr           instruction word from fetch
//   i_instrValid      fetch has a word on i_instr
//   o_instrReady      sequencer accepts a word at this edge
//   i_faultClr        leaves the FAULT state and clears the fault flag/code
//   o_TIn             IR is a T-type instruction
//   o_TWCtrl          T register write strobe
//   o_RWCtrl          R register write strobe
//   o_carryWCtrl      carry flag write strobe
//   o_stkAddrSel      stack address select (1 = SP-1, 0 = SP)
//   o_stkWCtrl        stack RAM write strobe
//   o_instrOP         ALU opcode, IR[3:7]
//   o_jSelCtrl        jump condition select, IR[9:11]
//   o_jCtrl           jump control field, zero unless T-type
//   o_sp              stack pointer
//   o_stkEmpty        SP == 0
//   o_stkFull         SP == 2^SPW-1
//   o_fault           sticky stack fault
//   o_faultCode       01 overflow, 10 underflow, 00 none
module stack_ctrl_sequencer #(
  parameter int IW  = 18,
  parameter int SPW = 4,
  parameter int JW  = 6
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [IW-1:0]  i_instr,
  input  logic           i_instrValid,
  output logic           o_instrReady,
  input  logic           i_faultClr,
  output logic           o_TIn,
  output logic           o_TWCtrl,
  output logic           o_RWCtrl,
  output logic           o_carryWCtrl,
  output logic           o_stkAddrSel,
  output logic           o_stkWCtrl,
  output logic [4:0]     o_instrOP,
  output logic [2:0]     o_jSelCtrl,
  output logic [JW-1:0]  o_jCtrl,
  output logic [SPW-1:0] o_sp,
  output logic           o_stkEmpty,
  output logic           o_stkFull,
  output logic           o_fault,
  output logic [1:0]     o_faultCode
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    STK_NONE = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10,
    STK_SWAP = 2'b11
  } stk_op_t;

  state_t         state_q, state_d;
  // ir_q[k] holds instruction bit k in big-endian numbering.
  logic [17:0]    ir_q, ir_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           fault_q, fault_d;
  logic [1:0]     code_q, code_d;

  logic [17:0]    ir_load;
  logic           t_type;
  logic           two_cycle;
  stk_op_t        stk_op;
  logic           is_push, is_pop, is_swap;
  logic           sp_full, sp_empty;
  logic           ovf, unf, stk_fault;
  logic [JW-1:0]  jfield;
  logic           ready;
  logic           accept;
  logic           tw, rw, carry, asel, stkw;
  logic           unused_ir;

  // Bit 8 has no control meaning in this decoder.
  assign unused_ir = ir_q[8];

  // Reverse the port vector so that IR index k matches instruction bit k.
  always_comb begin
    ir_load = '0;
    for (int unsigned k = 0; k < 18; k++) begin
      ir_load[k] = i_instr[IW-1-k];
    end
  end

  always_comb begin
    jfield = '0;
    for (int unsigned b = 0; b < JW; b++) begin
      jfield[JW-1-b] = ir_q[12+b];
    end
  end

  assign t_type    = ir_q[0] & ir_q[1];
  assign stk_op    = t_type ? stk_op_t'({ir_q[3], ir_q[4]}) : STK_NONE;
  assign is_push   = (stk_op == STK_PUSH);
  assign is_pop    = (stk_op == STK_POP);
  assign is_swap   = (stk_op == STK_SWAP);
  assign two_cycle = t_type & ir_q[2] & ir_q[7];

  assign sp_full   = (sp_q == '1);
  assign sp_empty  = (sp_q == '0);
  assign ovf       = is_push & sp_full;
  assign unf       = is_pop & sp_empty;
  // Only meaningful during EXEC. A faulting op must not show any strobe
  // in its own EXEC cycle, so this gates the strobes combinationally.
  assign stk_fault = (state_q == S_EXEC) & (ovf | unf);

  // Ready depends only on registered state, never on i_instrValid. Fetch
  // therefore sees a stable ready for the whole cycle.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      S_IDLE:  ready = 1'b1;
      S_EXEC:  ready = ~two_cycle & ~stk_fault;
      S_WB:    ready = 1'b1;
      S_FAULT: ready = 1'b0;
      default: ready = 1'b0;
    endcase
  end

  assign accept = i_instrValid & ready;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    sp_d    = sp_q;
    fault_d = fault_q;
    code_d  = code_q;
    tw      = 1'b0;
    rw      = 1'b0;
    carry   = 1'b0;
    asel    = 1'b0;
    stkw    = 1'b0;

    if (accept) begin
      ir_d = ir_load;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (stk_fault) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = ovf ? 2'b01 : 2'b10;
        end else begin
          tw    = t_type | ~ir_q[2] | ir_q[5];
          rw    = t_type & ir_q[6];
          carry = t_type & ir_q[2];
          asel  = is_pop | is_swap;
          if (is_push) begin
            sp_d = sp_q + SPW'(1);
          end else if (is_pop) begin
            sp_d = sp_q - SPW'(1);
          end
          if (two_cycle) begin
            state_d = S_WB;
          end else if (accept) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_WB: begin
        stkw    = 1'b1;
        state_d = accept ? S_EXEC : S_IDLE;
      end

      S_FAULT: begin
        if (i_faultClr) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          code_d  = 2'b00;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      sp_q    <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign o_instrReady = ready;
  assign o_TIn        = t_type;
  assign o_TWCtrl     = tw;
  assign o_RWCtrl     = rw;
  assign o_carryWCtrl = carry;
  assign o_stkAddrSel = asel;
  assign o_stkWCtrl   = stkw;
  assign o_instrOP    = {ir_q[3], ir_q[4], ir_q[5], ir_q[6], ir_q[7]};
  assign o_jSelCtrl   = {ir_q[9], ir_q[10], ir_q[11]};
  assign o_jCtrl      = t_type ? jfield : '0;
  assign o_sp         = sp_q;
  assign o_stkEmpty   = sp_empty;
  assign o_stkFull    = sp_full;
  assign o_fault      = fault_q;
  assign o_faultCode  = code_q;

endmodule

// File: tb/tb_stack_ctrl_sequencer.sv
// Testbench for stack_ctrl_sequencer (SPW=2, stack depth 4).
//   A cycle-level reference model tracks the stack pointer, the instruction
//   in flight and its phase (first cycle / write-back), and the sticky fault.
//   All outputs are compared against it at every falling edge.
//   Directed literal checks pin the key scenarios.
module tb_stack_ctrl_sequencer;
  localparam int IW    = 18;
  localparam int SPW   = 2;
  localparam int JW    = 6;
  localparam int SPMAX = (1 << SPW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [IW-1:0]  instr;
  logic           valid, clr;
  logic           o_instrReady, o_TIn, o_TWCtrl, o_RWCtrl, o_carryWCtrl;
  logic           o_stkAddrSel, o_stkWCtrl, o_stkEmpty, o_stkFull, o_fault;
  logic [4:0]     o_instrOP;
  logic [2:0]     o_jSelCtrl;
  logic [JW-1:0]  o_jCtrl;
  logic [SPW-1:0] o_sp;
  logic [1:0]     o_faultCode;

  stack_ctrl_sequencer #(.IW(IW), .SPW(SPW), .JW(JW)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_instrValid(valid),
    .o_instrReady(o_instrReady), .i_faultClr(clr), .o_TIn(o_TIn),
    .o_TWCtrl(o_TWCtrl), .o_RWCtrl(o_RWCtrl), .o_carryWCtrl(o_carryWCtrl),
    .o_stkAddrSel(o_stkAddrSel), .o_stkWCtrl(o_stkWCtrl),
    .o_instrOP(o_instrOP), .o_jSelCtrl(o_jSelCtrl), .o_jCtrl(o_jCtrl),
    .o_sp(o_sp), .o_stkEmpty(o_stkEmpty), .o_stkFull(o_stkFull),
    .o_fault(o_fault), .o_faultCode(o_faultCode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Fields are listed in big-endian order: bits 0-1, 2, 3-7 (opcode), 8, 9-11, 12-17.
  function automatic logic [17:0] mk(input logic [1:0] b01, input logic b2,
                                     input logic [4:0] op, input logic [2:0] sel,
                                     input logic [5:0] j);
    return {b01, b2, op, 1'b0, sel, j};
  endfunction

  // ---------------- reference model ----------------
  // Instruction bit k is x[17-k].
  int          m_sp;
  bit          m_flt;
  logic [1:0]  m_code;
  logic [17:0] m_cur;
  int          m_phase;   // 0 nothing running, 1 first cycle, 2 write-back cycle

  task automatic model_reset();
    m_sp = 0; m_flt = 0; m_code = 2'b00; m_cur = '0; m_phase = 0;
  endtask

  function automatic bit m_t();         return m_cur[17] & m_cur[16]; endfunction
  function automatic logic [1:0] m_stk(); return m_t() ? m_cur[14:13] : 2'b00; endfunction
  function automatic bit m_two();       return m_t() & m_cur[15] & m_cur[10]; endfunction
  function automatic bit m_willflt();
    return (m_stk() == 2'b01 && m_sp == SPMAX) || (m_stk() == 2'b10 && m_sp == 0);
  endfunction
  function automatic bit m_ready();
    return !m_flt && (m_phase != 1 || (!m_two() && !m_willflt()));
  endfunction

  function automatic logic [29:0] m_expect();
    logic tw, rw, cy, as, sw;
    tw = 0; rw = 0; cy = 0; as = 0; sw = 0;
    if (!m_flt && m_phase == 1 && !m_willflt()) begin
      tw = m_t() | ~m_cur[15] | m_cur[12];
      rw = m_t() & m_cur[11];
      cy = m_t() & m_cur[15];
      as = (m_stk() == 2'b10) || (m_stk() == 2'b11);
    end
    if (!m_flt && m_phase == 2) sw = 1;
    return {m_ready(), m_t(), tw, rw, cy, as, sw, m_cur[14:10], m_cur[8:6],
            (m_t() ? m_cur[5:0] : 6'd0), 4'(m_sp), (m_sp == 0), (m_sp == SPMAX),
            m_flt, m_code};
  endfunction

  task automatic model_step();
    bit acc, wf;
    acc = valid && m_ready();
    wf  = m_willflt();
    if (m_flt) begin
      if (clr) begin m_flt = 0; m_code = 2'b00; end
    end else if (m_phase == 1) begin
      if (wf) begin
        m_flt = 1; m_code = (m_stk() == 2'b01) ? 2'b01 : 2'b10; m_phase = 0;
      end else begin
        if (m_stk() == 2'b01) m_sp++;
        if (m_stk() == 2'b10) m_sp--;
        if (m_two()) m_phase = 2;
        else if (acc) begin m_cur = instr[17:0]; m_phase = 1; end
        else m_phase = 0;
      end
    end else begin
      if (acc) begin m_cur = instr[17:0]; m_phase = 1; end
      else m_phase = 0;
    end
  endtask

  logic [29:0] actv;
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      actv = {o_instrReady, o_TIn, o_TWCtrl, o_RWCtrl, o_carryWCtrl, o_stkAddrSel,
              o_stkWCtrl, o_instrOP, o_jSelCtrl, o_jCtrl, {2'b00, o_sp}, o_stkEmpty,
              o_stkFull, o_fault, o_faultCode};
      chk("model_cycle", 32'(actv), 32'(m_expect()));
      if (!rst) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [17:0] ins, input logic c);
    valid = v; instr = ins; clr = c;
    @(posedge clk); #1;
  endtask

  // Hold the word valid until it is taken. Returns one cycle after acceptance.
  task automatic issue(input logic [17:0] ins);
    logic acc;
    int   n;
    valid = 1'b1; instr = ins; clr = 1'b0; n = 0;
    do begin
      @(negedge clk);
      acc = o_instrReady;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 20);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL issue_timeout actual=notaccepted required=accepted");
    end
    valid = 1'b0;
  endtask

  logic [17:0] nt1, nt2, nt3, push1, push2, pop1, swp, j1, j2;

  initial begin
    nt1   = mk(2'b00, 1'b0, 5'h03, 3'b001, 6'h2A);
    nt2   = mk(2'b01, 1'b1, 5'h11, 3'b010, 6'h15);
    nt3   = mk(2'b10, 1'b0, 5'h1E, 3'b011, 6'h3F);
    push1 = mk(2'b11, 1'b0, 5'b01000, 3'b000, 6'h00);
    push2 = mk(2'b11, 1'b1, 5'b01001, 3'b000, 6'h00);
    pop1  = mk(2'b11, 1'b0, 5'b10000, 3'b000, 6'h00);
    swp   = mk(2'b11, 1'b0, 5'b11000, 3'b000, 6'h00);
    j1    = mk(2'b11, 1'b0, 5'b00000, 3'b110, 6'b101101);
    j2    = mk(2'b01, 1'b0, 5'b00000, 3'b110, 6'b101101);

    rst = 1'b1; valid = 1'b0; clr = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sp", 32'(o_sp), 0);
    chk("reset_ready", 32'(o_instrReady), 1);
    chk("reset_outs", {o_TWCtrl, o_RWCtrl, o_carryWCtrl, o_stkAddrSel, o_stkWCtrl,
                       o_instrOP, o_jSelCtrl, o_jCtrl, o_fault, o_faultCode}, 0);
    rst = 1'b0;
    step(0, '0, 0);

    // back-to-back single-cycle, non-T
    issue(nt1);
    chk("b2b_op1", 32'(o_instrOP), 32'h03);
    chk("b2b_j1", 32'(o_jCtrl), 0);
    chk("b2b_rdy1", 32'(o_instrReady), 1);
    issue(nt2);
    chk("b2b_op2", 32'(o_instrOP), 32'h11);
    issue(nt3);
    chk("b2b_op3", 32'(o_instrOP), 32'h1E);
    step(0, '0, 0);

    // single-cycle push 0->1, then two-cycle push 1->2
    issue(push1);
    chk("push1_tw", 32'(o_TWCtrl), 1);
    step(0, '0, 0);
    chk("push1_sp", 32'(o_sp), 1);
    issue(push2);
    chk("push2_exec_ready", 32'(o_instrReady), 0);
    chk("push2_exec_carry", 32'(o_carryWCtrl), 1);
    chk("push2_exec_stkw", 32'(o_stkWCtrl), 0);
    step(0, '0, 0);
    chk("push2_wb_stkw", 32'(o_stkWCtrl), 1);
    chk("push2_wb_sp", 32'(o_sp), 2);
    chk("push2_wb_ready", 32'(o_instrReady), 1);
    step(0, '0, 0);

    // two-cycle push 2->3, reset in the middle of write-back
    issue(push2);
    step(0, '0, 0);
    chk("midwb_stkw", 32'(o_stkWCtrl), 1);
    chk("midwb_sp", 32'(o_sp), 3);
    rst = 1'b1;
    #1;
    chk("rst_midwb_stkw", 32'(o_stkWCtrl), 0);
    chk("rst_midwb_sp", 32'(o_sp), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(o_instrReady), 1);
    chk("rst_release_outs", {o_TIn, o_TWCtrl, o_stkWCtrl, o_instrOP, o_jCtrl, o_fault}, 0);
    step(0, '0, 0);

    // overflow: the fourth push faults
    issue(push1); issue(push1); issue(push1); issue(push1);
    chk("ovf_exec_tw", 32'(o_TWCtrl), 0);
    chk("ovf_exec_ready", 32'(o_instrReady), 0);
    chk("ovf_exec_sp", 32'(o_sp), 3);
    step(1, push1, 0); step(1, push1, 0); step(1, push1, 0);
    chk("ovf_fault", 32'(o_fault), 1);
    chk("ovf_code", 32'(o_faultCode), 1);
    chk("ovf_sp", 32'(o_sp), 3);
    chk("ovf_ready", 32'(o_instrReady), 0);
    step(0, '0, 1);
    chk("ovf_clr_fault", 32'(o_fault), 0);
    chk("ovf_clr_code", 32'(o_faultCode), 0);
    chk("ovf_clr_sp", 32'(o_sp), 3);
    chk("ovf_clr_ready", 32'(o_instrReady), 1);
    step(0, '0, 1);   // clear outside FAULT does nothing
    chk("clr_idle_sp", 32'(o_sp), 3);

    // pops down to 0, then underflow
    issue(pop1);
    chk("pop_asel", 32'(o_stkAddrSel), 1);
    issue(pop1); issue(pop1);
    step(0, '0, 0);
    chk("pop_sp0", 32'(o_sp), 0);
    issue(pop1);
    chk("unf_asel", 32'(o_stkAddrSel), 0);
    chk("unf_tw", 32'(o_TWCtrl), 0);
    step(0, '0, 0);
    chk("unf_code", 32'(o_faultCode), 2);
    chk("unf_sp", 32'(o_sp), 0);
    step(0, '0, 1);

    // swap at SP 0 never faults
    issue(swp);
    chk("swap_asel", 32'(o_stkAddrSel), 1);
    step(0, '0, 0);
    chk("swap_nofault", 32'(o_fault), 0);

    // jump gating
    issue(j1);
    chk("jmp_t_jctrl", 32'(o_jCtrl), 32'b101101);
    chk("jmp_t_jsel", 32'(o_jSelCtrl), 32'b110);
    issue(j2);
    chk("jmp_nt_jctrl", 32'(o_jCtrl), 0);
    chk("jmp_nt_jsel", 32'(o_jSelCtrl), 32'b110);
    step(0, '0, 0);
    step(0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
